// File: rtl/alu_operand_stage.sv
// RV64I execute-issue stage: decodes the instruction into ALU op/operands plus
// writeback metadata, buffered through a 2-entry output/skid register pair.
module alu_operand_stage #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [3:0]      op_o,
   output logic [XLEN-1:0] in1_o,
   output logic [XLEN-1:0] in2_o,
   output logic [4:0]      rd_o,
   output logic            word_o,
   output logic            illegal_o
);

   // ALU operation encoding shared with the alu block
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   typedef struct packed {
      logic [3:0]      op;
      logic [XLEN-1:0] in1;
      logic [XLEN-1:0] in2;
      logic [4:0]      rd;
      logic            word;
      logic            illegal;
   } bundle_t;

   localparam bundle_t BUNDLE_RST = '{op: ALU_ADD, in1: '0, in2: '0, rd: '0,
                                      word: 1'b0, illegal: 1'b0};

   bundle_t         dec;
   bundle_t         or_q, sk_q;
   logic            or_valid_q, sk_valid_q;
   logic            accept, emit;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_u, rs1_zext, rs1_sext;

   assign f3       = inst_i[14:12];
   assign f7       = inst_i[31:25];
   assign imm_i    = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
   assign imm_u    = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
   assign rs1_zext = {{(XLEN-32){1'b0}}, rs1_data_i[31:0]};
   assign rs1_sext = {{(XLEN-32){rs1_data_i[31]}}, rs1_data_i[31:0]};

   always_comb begin
      dec         = BUNDLE_RST;
      dec.rd      = inst_i[11:7];
      dec.in1     = rs1_data_i;
      dec.in2     = rs2_data_i;
      case (inst_i[6:0])
         7'h13: begin
            dec.in2 = imm_i;
            case (f3)
               3'd0: dec.op = ALU_ADD;
               3'd1: begin
                  dec.op      = ALU_SLL;
                  dec.in2     = {{(XLEN-6){1'b0}}, inst_i[25:20]};
                  dec.illegal = (inst_i[31:26] != 6'b000000);
               end
               3'd2: dec.op = ALU_SLT;
               3'd3: dec.op = ALU_SLTU;
               3'd4: dec.op = ALU_XOR;
               3'd5: begin
                  dec.op      = inst_i[30] ? ALU_SRA : ALU_SRL;
                  dec.in2     = {{(XLEN-6){1'b0}}, inst_i[25:20]};
                  dec.illegal = (inst_i[31:26] != 6'b000000) && (inst_i[31:26] != 6'b010000);
               end
               3'd6: dec.op = ALU_OR;
               default: dec.op = ALU_AND;
            endcase
         end
         7'h33: begin
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: dec.op = ALU_ADD;
                  3'd1: dec.op = ALU_SLL;
                  3'd2: dec.op = ALU_SLT;
                  3'd3: dec.op = ALU_SLTU;
                  3'd4: dec.op = ALU_XOR;
                  3'd5: dec.op = ALU_SRL;
                  3'd6: dec.op = ALU_OR;
                  default: dec.op = ALU_AND;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) dec.op = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) dec.op = ALU_SRA;
            else dec.illegal = 1'b1;
         end
         7'h37: begin
            dec.in1 = '0;
            dec.in2 = imm_u;
         end
         7'h17: begin
            dec.in1 = pc_i;
            dec.in2 = imm_u;
         end
         7'h1B: begin
            dec.word = 1'b1;
            dec.in2  = {{(XLEN-5){1'b0}}, inst_i[24:20]};
            if (f3 == 3'd0) dec.in2 = imm_i;
            else if (f3 == 3'd1 && f7 == 7'h00) dec.op = ALU_SLL;
            else if (f3 == 3'd5 && f7 == 7'h00) begin
               dec.op  = ALU_SRL;
               dec.in1 = rs1_zext;
            end else if (f3 == 3'd5 && f7 == 7'h20) begin
               dec.op  = ALU_SRA;
               dec.in1 = rs1_sext;
            end else dec.illegal = 1'b1;
         end
         7'h3B: begin
            dec.word = 1'b1;
            if (f3 != 3'd0) dec.in2 = {{(XLEN-5){1'b0}}, rs2_data_i[4:0]};
            if (f7 == 7'h00 && f3 == 3'd0) dec.op = ALU_ADD;
            else if (f7 == 7'h20 && f3 == 3'd0) dec.op = ALU_SUB;
            else if (f7 == 7'h00 && f3 == 3'd1) dec.op = ALU_SLL;
            else if (f7 == 7'h00 && f3 == 3'd5) begin
               dec.op  = ALU_SRL;
               dec.in1 = rs1_zext;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
               dec.op  = ALU_SRA;
               dec.in1 = rs1_sext;
            end else dec.illegal = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // Illegal bundles travel with neutral operands so the ALU sees a harmless ADD
      if (dec.illegal) begin
         dec.op   = ALU_ADD;
         dec.in1  = '0;
         dec.in2  = '0;
         dec.word = 1'b0;
      end
   end

   assign accept = valid_i && ready_o;
   assign emit   = or_valid_q && ready_i;

   // Accept is only possible with SK empty, so the SK->OR move never coincides with a refill
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         or_q       <= BUNDLE_RST;
         sk_q       <= BUNDLE_RST;
         or_valid_q <= 1'b0;
         sk_valid_q <= 1'b0;
         ready_o    <= 1'b1;
      end else begin
         if (emit && sk_valid_q) begin
            or_q       <= sk_q;
            sk_valid_q <= 1'b0;
            ready_o    <= 1'b1;
         end else if (accept && (!or_valid_q || emit)) begin
            or_q       <= dec;
            or_valid_q <= 1'b1;
         end else if (accept) begin
            sk_q       <= dec;
            sk_valid_q <= 1'b1;
            ready_o    <= 1'b0;
         end else if (emit) begin
            or_valid_q <= 1'b0;
         end
      end
   end

   assign valid_o   = or_valid_q;
   assign op_o      = or_q.op;
   assign in1_o     = or_q.in1;
   assign in2_o     = or_q.in2;
   assign rd_o      = or_q.rd;
   assign word_o    = or_q.word;
   assign illegal_o = or_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: expected bundles are queued on accept
// and compared field by field when the stage emits them.
module tb_alu_operand_stage;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;

   logic        clk_i = 1'b0;
   logic        reset_i, valid_i, ready_o, valid_o, ready_i;
   logic [31:0] inst_i;
   logic [63:0] pc_i, rs1_data_i, rs2_data_i, in1_o, in2_o;
   logic [3:0]  op_o;
   logic [4:0]  rd_o;
   logic        word_o, illegal_o;

   typedef struct packed {
      logic [3:0]  op;
      logic [63:0] in1;
      logic [63:0] in2;
      logic [4:0]  rd;
      logic        word;
      logic        illegal;
   } exp_t;

   exp_t sb[$];
   exp_t pend;
   int   checks = 0;
   int   failures = 0;

   always #5 clk_i = ~clk_i;

   alu_operand_stage #(.XLEN(64)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
      .inst_i(inst_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .valid_o(valid_o), .ready_i(ready_i), .op_o(op_o), .in1_o(in1_o), .in2_o(in2_o),
      .rd_o(rd_o), .word_o(word_o), .illegal_o(illegal_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [3:0] op, input logic [63:0] in1,
                        input logic [63:0] in2, input logic [4:0] rd, input logic word,
                        input logic ill);
      valid_i    = 1'b1;
      inst_i     = inst;
      pc_i       = pc;
      rs1_data_i = rs1;
      rs2_data_i = rs2;
      pend       = '{op: op, in1: in1, in2: in2, rd: rd, word: word, illegal: ill};
   endtask

   // One clock: compare any emission, log any acceptance, then step past the edge
   task automatic cycle();
      exp_t e;
      @(negedge clk_i);
      if (valid_o && ready_i) begin
         if (sb.size() == 0) chk("spurious_emit", {63'b0, valid_o}, 64'd0);
         else begin
            e = sb.pop_front();
            chk("op", {60'b0, op_o}, {60'b0, e.op});
            chk("in1", in1_o, e.in1);
            chk("in2", in2_o, e.in2);
            chk("rd", {59'b0, rd_o}, {59'b0, e.rd});
            chk("word", {63'b0, word_o}, {63'b0, e.word});
            chk("illegal", {63'b0, illegal_o}, {63'b0, e.illegal});
         end
      end
      if (reset_i) sb.delete();
      else if (valid_i && ready_o) sb.push_back(pend);
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      reset_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
      inst_i = 32'hFFF08293; pc_i = '0; rs1_data_i = 64'h10; rs2_data_i = '0;
      pend = '0;
      cycle();
      chk("rst_valid", {63'b0, valid_o}, 64'd0);
      chk("rst_ready", {63'b0, ready_o}, 64'd1);
      chk("rst_illegal", {63'b0, illegal_o}, 64'd0);
      chk("rst_word", {63'b0, word_o}, 64'd0);
      chk("rst_rd", {59'b0, rd_o}, 64'd0);
      chk("rst_op", {60'b0, op_o}, {60'b0, ALU_ADD});
      chk("rst_in1", in1_o, 64'd0);
      chk("rst_in2", in2_o, 64'd0);
      valid_i = 1'b0;
      reset_i = 1'b0;
      cycle();

      // single ADDI with latency check
      offer(32'hFFF08293, 64'h0, 64'h10, 64'h0, ALU_ADD, 64'h10, 64'hFFFFFFFFFFFFFFFF, 5'd5, 1'b0, 1'b0);
      cycle();
      valid_i = 1'b0;
      chk("latency_valid", {63'b0, valid_o}, 64'd1);
      drain();

      // back-to-back stream of assorted decodes
      offer(32'h4040D31B, 64'h0, 64'h0000000080000000, 64'h0, ALU_SRA, 64'hFFFFFFFF80000000, 64'd4, 5'd6, 1'b1, 1'b0);
      cycle();
      offer(32'h123453B7, 64'h0, 64'h5555, 64'h0, ALU_ADD, 64'h0, 64'h0000000012345000, 5'd7, 1'b0, 1'b0);
      cycle();
      offer(32'h80000397, 64'h1000, 64'h5555, 64'h0, ALU_ADD, 64'h1000, 64'hFFFFFFFF80000000, 5'd7, 1'b0, 1'b0);
      cycle();
      offer(32'h0020D1BB, 64'h0, 64'hDEADBEEFF0000000, 64'h45, ALU_SRL, 64'h00000000F0000000, 64'd5, 5'd3, 1'b1, 1'b0);
      cycle();
      offer(32'h40310233, 64'h0, 64'h1234, 64'h99, ALU_SUB, 64'h1234, 64'h99, 5'd4, 1'b0, 1'b0);
      cycle();
      offer(32'h00000000, 64'h40, 64'hABCD, 64'h77, ALU_ADD, 64'h0, 64'h0, 5'd0, 1'b0, 1'b1);
      cycle();
      offer(32'h027302B3, 64'h0, 64'hABCD, 64'h77, ALU_ADD, 64'h0, 64'h0, 5'd5, 1'b0, 1'b1);
      cycle();
      offer(32'h0200909B, 64'h0, 64'hABCD, 64'h77, ALU_ADD, 64'h0, 64'h0, 5'd1, 1'b0, 1'b1);
      cycle();
      offer(32'hFFF08293, 64'h0, 64'h10, 64'h0, ALU_ADD, 64'h10, 64'hFFFFFFFFFFFFFFFF, 5'd5, 1'b0, 1'b0);
      cycle();
      valid_i = 1'b0;
      drain();

      // backpressure: A, B fill both entries, C is held off
      ready_i = 1'b0;
      offer(32'h00100093, 64'h0, 64'hA, 64'h0, ALU_ADD, 64'hA, 64'd1, 5'd1, 1'b0, 1'b0);
      cycle();
      offer(32'h00200113, 64'h0, 64'hB, 64'h0, ALU_ADD, 64'hB, 64'd2, 5'd2, 1'b0, 1'b0);
      cycle();
      chk("bp_ready_low", {63'b0, ready_o}, 64'd0);
      offer(32'h00300193, 64'h0, 64'hC, 64'h0, ALU_ADD, 64'hC, 64'd3, 5'd3, 1'b0, 1'b0);
      cycle();
      chk("bp_ready_held", {63'b0, ready_o}, 64'd0);
      chk("bp_hold_rd", {59'b0, rd_o}, 64'd1);
      chk("bp_hold_in1", in1_o, 64'hA);
      ready_i = 1'b1;
      cycle();
      chk("bp_ready_back", {63'b0, ready_o}, 64'd1);
      cycle();
      valid_i = 1'b0;
      drain();

      // reset with both entries full discards them
      ready_i = 1'b0;
      offer(32'h00100093, 64'h0, 64'hA, 64'h0, ALU_ADD, 64'hA, 64'd1, 5'd1, 1'b0, 1'b0);
      cycle();
      offer(32'h00200113, 64'h0, 64'hB, 64'h0, ALU_ADD, 64'hB, 64'd2, 5'd2, 1'b0, 1'b0);
      cycle();
      valid_i = 1'b0;
      chk("pre_rst_full", {63'b0, ready_o}, 64'd0);
      reset_i = 1'b1;
      cycle();
      reset_i = 1'b0;
      chk("mid_rst_valid", {63'b0, valid_o}, 64'd0);
      chk("mid_rst_ready", {63'b0, ready_o}, 64'd1);
      chk("mid_rst_in1", in1_o, 64'd0);
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("post_rst_quiet", {63'b0, valid_o}, 64'd0);
      end

      offer(32'h40310233, 64'h0, 64'h7, 64'h3, ALU_SUB, 64'h7, 64'h3, 5'd4, 1'b0, 1'b0);
      cycle();
      valid_i = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
